ptp_clock_ctrl: RTL and testbench

PTP_CLOCK_CTRL -- requirements
Module: ptp_clock_ctrl

---
 rtl/ptp_clock_ctrl_pkg.sv | 35 +++
 rtl/ptp_clock_ctrl_if.sv | 53 +++++
 rtl/ptp_ts_add_ns.sv | 34 +++
 rtl/ptp_clock_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ptp_clock_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ptp_clock_ctrl_pkg.sv
// Shared definitions for the PTP clock controller: request and FSM encodings,
// the nanoseconds-per-second constant and the 96-bit timestamp field layout.
package ptp_clock_ctrl_pkg;

   typedef enum logic [1:0] {
      REQ_SET_TIME   = 2'd0,
      REQ_OFFSET     = 2'd1,
      REQ_SET_PERIOD = 2'd2,
      REQ_RESERVED   = 2'd3
   } req_type_e;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DECODE    = 3'd1,
      STEP_CALC = 3'd2,
      ISSUE     = 3'd3,
      SLEW_WAIT = 3'd4
   } state_e;

   localparam longint NS_PER_SEC = 64'sd1_000_000_000;

   // Timestamp layout: {sec[47:0], ns[31:0], fns[15:0]}
   localparam int TS_W       = 96;
   localparam int TS_FNS_LSB = 0;
   localparam int TS_FNS_W   = 16;
   localparam int TS_NS_LSB  = 16;
   localparam int TS_NS_W    = 32;
   localparam int TS_SEC_LSB = 48;
   localparam int TS_SEC_W   = 48;

   // Period payload layout: {ns[3:0], fns[15:0]} in the low 20 bits
   localparam int PER_FNS_LSB = 0;
   localparam int PER_NS_LSB  = 16;

endpackage

// File: rtl/ptp_clock_ctrl_if.sv
// Bundle of request handshakes, clock time input and command outputs between
// the requesters/clock (master) and the PTP clock controller (slave).
interface ptp_clock_ctrl_if;
   import ptp_clock_ctrl_pkg::*;

   logic            req0_valid;
   logic            req0_ready;
   logic [1:0]      req0_type;
   logic [TS_W-1:0] req0_data;
   logic            req1_valid;
   logic            req1_ready;
   logic [1:0]      req1_type;
   logic [TS_W-1:0] req1_data;

   logic [TS_W-1:0] ts_96;
   logic            adj_active;

   logic [TS_W-1:0] set_ts_96;
   logic            set_ts_96_valid;
   logic [3:0]      set_period_ns;
   logic [15:0]     set_period_fns;
   logic            set_period_valid;
   logic [3:0]      adj_ns;
   logic [15:0]     adj_fns;
   logic [31:0]     adj_count;
   logic            adj_valid;
   logic            busy;
   logic            err;
   logic            grant;

   modport master (
      output req0_valid, req0_type, req0_data,
      output req1_valid, req1_type, req1_data,
      output ts_96, adj_active,
      input  req0_ready, req1_ready,
      input  set_ts_96, set_ts_96_valid,
      input  set_period_ns, set_period_fns, set_period_valid,
      input  adj_ns, adj_fns, adj_count, adj_valid,
      input  busy, err, grant
   );

   modport slave (
      input  req0_valid, req0_type, req0_data,
      input  req1_valid, req1_type, req1_data,
      input  ts_96, adj_active,
      output req0_ready, req1_ready,
      output set_ts_96, set_ts_96_valid,
      output set_period_ns, set_period_fns, set_period_valid,
      output adj_ns, adj_fns, adj_count, adj_valid,
      output busy, err, grant
   );

endinterface

// File: rtl/ptp_ts_add_ns.sv
// Combinational add of a signed ns offset to a 96-bit timestamp with a single
// second carry/borrow; sec wraps modulo 2^48 and fns passes through.
module ptp_ts_add_ns
   import ptp_clock_ctrl_pkg::*;
#(
   parameter int OFFSET_W = 32
)(
   input  logic [TS_W-1:0]            ts_in,
   input  logic signed [OFFSET_W-1:0] offset,
   output logic [TS_W-1:0]            ts_out
);

   logic signed [63:0]  ns_sum;
   logic signed [63:0]  ns_fix;
   logic [TS_SEC_W-1:0] sec_in;
   logic [TS_SEC_W-1:0] sec_fix;

   // Callers keep |offset| below one second, so one correction is enough.
   always_comb begin
      sec_in  = ts_in[TS_SEC_LSB +: TS_SEC_W];
      ns_sum  = 64'(signed'({1'b0, ts_in[TS_NS_LSB +: TS_NS_W]})) + 64'(offset);
      ns_fix  = ns_sum;
      sec_fix = sec_in;
      if (ns_sum >= NS_PER_SEC) begin
         ns_fix  = ns_sum - NS_PER_SEC;
         sec_fix = sec_in + TS_SEC_W'(1);
      end else if (ns_sum < 64'sd0) begin
         ns_fix  = ns_sum + NS_PER_SEC;
         sec_fix = sec_in - TS_SEC_W'(1);
      end
      ts_out = {sec_fix, ns_fix[TS_NS_W-1:0], ts_in[TS_FNS_LSB +: TS_FNS_W]};
   end

endmodule

// File: rtl/ptp_clock_ctrl.sv
// PTP clock controller: arbitrates two requesters and turns set-time, set-period
// and offset requests into step, slew or load commands for the local clock.
module ptp_clock_ctrl
   import ptp_clock_ctrl_pkg::*;
#(
   parameter int OFFSET_W    = 32,
   parameter int STEP_THRESH = 1000
)(
   input logic             clk,
   input logic             rst,
   ptp_clock_ctrl_if.slave bus
);

   localparam logic [63:0] THRESH_U = 64'(STEP_THRESH);
   localparam logic [63:0] NS_U     = 64'(NS_PER_SEC);

   // One extra bit so the most-negative offset has a representable magnitude.
   function automatic logic [OFFSET_W:0] abs_mag(input logic signed [OFFSET_W-1:0] v);
      logic signed [OFFSET_W:0] w;
      w = {v[OFFSET_W-1], v};
      return w[OFFSET_W] ? $unsigned(-w) : $unsigned(w);
   endfunction

   state_e                     state;
   state_e                     state_next;
   req_type_e                  type_p0;
   logic [TS_W-1:0]            data_p0;
   logic signed [OFFSET_W-1:0] offset_p0;
   logic [OFFSET_W:0]          mag_p0;
   logic [63:0]                mag64_p0;
   logic                       off_zero;
   logic                       off_err;
   logic                       off_step;
   logic                       off_slew;
   logic                       is_slew;

   logic                       win;
   logic                       idle_ok;
   logic                       xfer;
   logic                       grant_r;
   logic                       wait_armed;
   logic [TS_W-1:0]            step_ts;

   logic [TS_W-1:0]            set_ts_r;
   logic [3:0]                 per_ns_r;
   logic [15:0]                per_fns_r;
   logic [3:0]                 adj_ns_r;
   logic [15:0]                adj_fns_r;
   logic [31:0]                adj_count_r;
   logic                       set_ts_vld;
   logic                       per_vld;
   logic                       adj_vld;
   logic                       err_c;

   // Round-robin: on a tie the requester that did not win last time goes next.
   always_comb begin
      if (bus.req0_valid && bus.req1_valid) win = ~grant_r;
      else                                  win = bus.req1_valid;
   end

   assign idle_ok        = (state == IDLE) && !rst;
   assign bus.req0_ready = idle_ok && bus.req0_valid && !win;
   assign bus.req1_ready = idle_ok && bus.req1_valid && win;
   assign xfer           = (bus.req0_valid && bus.req0_ready) ||
                           (bus.req1_valid && bus.req1_ready);

   // Stage p0: request captured on the transfer cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_r <= 1'b1;
         type_p0 <= REQ_SET_TIME;
         data_p0 <= '0;
      end else if (xfer) begin
         grant_r <= win;
         type_p0 <= req_type_e'(win ? bus.req1_type : bus.req0_type);
         data_p0 <= win ? bus.req1_data : bus.req0_data;
      end
   end

   assign offset_p0 = signed'(data_p0[OFFSET_W-1:0]);
   assign mag_p0    = abs_mag(offset_p0);
   assign mag64_p0  = 64'(mag_p0);
   assign off_zero  = (mag64_p0 == 64'd0);
   assign off_err   = (mag64_p0 >= NS_U);
   assign off_step  = !off_err && (mag64_p0 >= THRESH_U);
   assign off_slew  = !off_err && !off_zero && (mag64_p0 < THRESH_U);
   assign is_slew   = (type_p0 == REQ_OFFSET) && off_slew;

   ptp_ts_add_ns #(.OFFSET_W(OFFSET_W)) u_ts_add (
      .ts_in  (bus.ts_96),
      .offset (offset_p0),
      .ts_out (step_ts)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      set_ts_vld = 1'b0;
      per_vld    = 1'b0;
      adj_vld    = 1'b0;
      err_c      = 1'b0;
      case (state)
         IDLE: begin
            if (xfer) state_next = DECODE;
         end
         DECODE: begin
            case (type_p0)
               REQ_SET_TIME, REQ_SET_PERIOD: state_next = ISSUE;
               REQ_OFFSET: begin
                  if (off_err) begin
                     err_c      = 1'b1;
                     state_next = IDLE;
                  end else if (off_zero) begin
                     state_next = IDLE;
                  end else if (off_step) begin
                     state_next = STEP_CALC;
                  end else begin
                     state_next = ISSUE;
                  end
               end
               default: begin
                  err_c      = 1'b1;
                  state_next = IDLE;
               end
            endcase
         end
         STEP_CALC: state_next = ISSUE;
         ISSUE: begin
            if (is_slew) begin
               adj_vld    = 1'b1;
               state_next = SLEW_WAIT;
            end else if (type_p0 == REQ_SET_PERIOD) begin
               per_vld    = 1'b1;
               state_next = IDLE;
            end else begin
               set_ts_vld = 1'b1;
               state_next = IDLE;
            end
         end
         // The first wait cycle is skipped: the clock may not yet reflect adj_valid.
         SLEW_WAIT: begin
            if (wait_armed && !bus.adj_active) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Stage p1: command registers, loaded on entry to ISSUE and held afterwards
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_armed  <= 1'b0;
         set_ts_r    <= '0;
         per_ns_r    <= '0;
         per_fns_r   <= '0;
         adj_ns_r    <= '0;
         adj_fns_r   <= '0;
         adj_count_r <= '0;
      end else begin
         wait_armed <= (state == SLEW_WAIT);
         if (state == DECODE && state_next == ISSUE) begin
            case (type_p0)
               REQ_SET_TIME: set_ts_r <= data_p0;
               REQ_SET_PERIOD: begin
                  per_ns_r  <= data_p0[PER_NS_LSB +: 4];
                  per_fns_r <= data_p0[PER_FNS_LSB +: 16];
               end
               default: begin
                  adj_ns_r    <= offset_p0[OFFSET_W-1] ? 4'hF : 4'h1;
                  adj_fns_r   <= '0;
                  adj_count_r <= 32'(mag_p0);
               end
            endcase
         end
         if (state == STEP_CALC) set_ts_r <= step_ts;
      end
   end

   assign bus.set_ts_96        = set_ts_r;
   assign bus.set_ts_96_valid  = set_ts_vld;
   assign bus.set_period_ns    = per_ns_r;
   assign bus.set_period_fns   = per_fns_r;
   assign bus.set_period_valid = per_vld;
   assign bus.adj_ns           = adj_ns_r;
   assign bus.adj_fns          = adj_fns_r;
   assign bus.adj_count        = adj_count_r;
   assign bus.adj_valid        = adj_vld;
   assign bus.err              = err_c;
   assign bus.busy             = (state != IDLE);
   assign bus.grant            = grant_r;

endmodule

// File: tb/tb_ptp_clock_ctrl.sv
// Bench for ptp_clock_ctrl: a vector table of single requests plus hand-written
// contention, slew-hold and reset-abort sequences, checked through a pulse scoreboard.
module tb_ptp_clock_ctrl;

   localparam int K_TS   = 0;
   localparam int K_PER  = 1;
   localparam int K_ADJ  = 2;
   localparam int K_ERR  = 3;
   localparam int K_NONE = 4;
   localparam int NV     = 14;

   typedef struct {
      int          idx;
      logic [1:0]  typ;
      logic [95:0] data;
      logic [95:0] ts;
      int          kind;
      int          lat;
      logic [95:0] pay;
      logic        grant;
   } vec_t;

   typedef struct {
      int          kind;
      int          cyc;
      logic [95:0] pay;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   vec_t vt[NV];

   ptp_clock_ctrl_if bus();

   ptp_clock_ctrl #(.OFFSET_W(32), .STEP_THRESH(1000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [95:0] tsf(input logic [47:0] s, input logic [31:0] n, input logic [15:0] f);
      return {s, n, f};
   endfunction

   function automatic logic [95:0] offd(input int v);
      return {64'd0, 32'(v)};
   endfunction

   function automatic logic [95:0] adjp(input logic [3:0] a, input logic [15:0] f, input logic [31:0] c);
      return {44'd0, a, f, c};
   endfunction

   function automatic logic [95:0] perp(input logic [3:0] n, input logic [15:0] f);
      return {76'd0, n, f};
   endfunction

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic drive_req(input int idx, input logic [1:0] t, input logic [95:0] d, input logic v);
      if (idx == 0) begin
         bus.req0_valid = v; bus.req0_type = t; bus.req0_data = d;
      end else begin
         bus.req1_valid = v; bus.req1_type = t; bus.req1_data = d;
      end
   endtask

   task automatic handshake(input int idx, output int xc, output bit ok);
      ok = 1'b0;
      xc = 0;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         if ((idx == 0) ? bus.req0_ready : bus.req1_ready) begin
            ok = 1'b1;
            xc = cyc;
         end
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 60 && !ok; n++) begin
         @(negedge clk);
         if (!bus.busy) ok = 1'b1;
      end
   endtask

   // Pulse monitor: every command/err pulse must match the head of the scoreboard.
   always @(negedge clk) begin : mon
      int          np;
      int          k;
      logic [95:0] pay;
      exp_t        e;
      if (!rst) begin
         np = int'(bus.set_ts_96_valid) + int'(bus.set_period_valid) +
              int'(bus.adj_valid) + int'(bus.err);
         if (np > 0) begin
            if (bus.set_ts_96_valid) begin
               k = K_TS;  pay = bus.set_ts_96;
            end else if (bus.set_period_valid) begin
               k = K_PER; pay = perp(bus.set_period_ns, bus.set_period_fns);
            end else if (bus.adj_valid) begin
               k = K_ADJ; pay = adjp(bus.adj_ns, bus.adj_fns, bus.adj_count);
            end else begin
               k = K_ERR; pay = '0;
            end
            chk("single_pulse", np, 1);
            if (sb.size() == 0) begin
               chk("unexpected_pulse_kind", k, K_NONE);
            end else begin
               e = sb.pop_front();
               chk("pulse_kind", k, e.kind);
               chk("pulse_cycle", cyc, e.cyc);
               chk("pulse_data", pay, e.pay);
            end
         end
      end
   end

   initial begin
      int xc;
      bit ok;
      int got;
      int w;

      vt[0]  = '{0, 2'd0, tsf(5, 10, 0), 96'd0, K_TS, 2, tsf(5, 10, 0), 1'b0};
      vt[1]  = '{1, 2'd1, offd(2000), tsf(100, 999_999_500, 16'h1234), K_TS, 3,
                 tsf(101, 1500, 16'h1234), 1'b1};
      vt[2]  = '{0, 2'd1, offd(-5000), tsf(7, 100, 16'hABCD), K_TS, 3,
                 tsf(6, 999_995_100, 16'hABCD), 1'b0};
      vt[3]  = '{0, 2'd1, offd(-300), 96'd0, K_ADJ, 2, adjp(4'hF, 16'd0, 300), 1'b0};
      vt[4]  = '{1, 2'd2, perp(4'd8, 16'h4000), 96'd0, K_PER, 2, perp(4'd8, 16'h4000), 1'b1};
      vt[5]  = '{1, 2'd1, offd(1_500_000_000), tsf(1, 2, 3), K_ERR, 1, 96'd0, 1'b1};
      vt[6]  = '{0, 2'd1, offd(0), 96'd0, K_NONE, 0, 96'd0, 1'b0};
      vt[7]  = '{0, 2'd3, tsf(9, 9, 9), 96'd0, K_ERR, 1, 96'd0, 1'b0};
      vt[8]  = '{1, 2'd1, offd(int'(32'h8000_0000)), 96'd0, K_ERR, 1, 96'd0, 1'b1};
      vt[9]  = '{1, 2'd1, offd(999), tsf(1, 1, 1), K_ADJ, 2, adjp(4'h1, 16'd0, 999), 1'b1};
      vt[10] = '{0, 2'd1, offd(1000), tsf(48'hFFFF_FFFF_FFFF, 999_999_000, 5), K_TS, 3,
                 tsf(0, 0, 5), 1'b0};
      vt[11] = '{1, 2'd1, offd(-1000), tsf(0, 999, 0), K_TS, 3,
                 tsf(48'hFFFF_FFFF_FFFF, 999_999_999, 0), 1'b1};
      vt[12] = '{0, 2'd1, offd(999_999_999), tsf(1, 0, 7), K_TS, 3,
                 tsf(1, 999_999_999, 7), 1'b0};
      vt[13] = '{1, 2'd1, offd(-1_000_000_000), 96'd0, K_ERR, 1, 96'd0, 1'b1};

      bus.req0_valid = 1'b1;
      bus.req0_type  = 2'd0;
      bus.req0_data  = '0;
      bus.req1_valid = 1'b0;
      bus.req1_type  = 2'd0;
      bus.req1_data  = '0;
      bus.ts_96      = '0;
      bus.adj_active = 1'b0;

      // Reset state, with a requester already valid
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req0_ready", bus.req0_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_grant", bus.grant, 1);
      chk("rst_set_ts", bus.set_ts_96, 0);
      chk("rst_period", perp(bus.set_period_ns, bus.set_period_fns), 0);
      chk("rst_adj", adjp(bus.adj_ns, bus.adj_fns, bus.adj_count), 0);
      chk("rst_err", bus.err, 0);
      bus.req0_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         bus.ts_96 = vt[i].ts;
         drive_req(vt[i].idx, vt[i].typ, vt[i].data, 1'b1);
         handshake(vt[i].idx, xc, ok);
         chk($sformatf("vec%0d_handshake", i), ok, 1);
         if (ok && vt[i].kind != K_NONE)
            sb.push_back(exp_t'{vt[i].kind, xc + vt[i].lat, vt[i].pay});
         @(posedge clk); #1;
         drive_req(vt[i].idx, vt[i].typ, vt[i].data, 1'b0);
         wait_idle(ok);
         chk($sformatf("vec%0d_idle", i), ok, 1);
         chk($sformatf("vec%0d_grant", i), bus.grant, vt[i].grant);
         chk($sformatf("vec%0d_missing_pulse", i), sb.size(), 0);
         sb.delete();
      end

      // Contention: both requesters held valid across four transactions
      @(posedge clk); #1;
      drive_req(0, 2'd2, perp(4'd1, 16'h0001), 1'b1);
      drive_req(1, 2'd2, perp(4'd2, 16'h0002), 1'b1);
      got = 0;
      for (int n = 0; n < 80 && got < 4; n++) begin
         @(negedge clk);
         if (bus.busy) chk("ready_while_busy", {bus.req0_ready, bus.req1_ready}, 0);
         if (bus.req0_ready || bus.req1_ready) begin
            w = bus.req1_ready ? 1 : 0;
            chk("rr_onehot", bus.req0_ready & bus.req1_ready, 0);
            chk($sformatf("rr_winner%0d", got), w, got % 2);
            sb.push_back(exp_t'{K_PER, cyc + 2, (w == 1) ? perp(4'd2, 16'h0002) : perp(4'd1, 16'h0001)});
            got++;
         end
      end
      chk("rr_transfers", got, 4);
      @(posedge clk); #1;
      drive_req(0, 2'd2, '0, 1'b0);
      drive_req(1, 2'd2, '0, 1'b0);
      wait_idle(ok);
      chk("rr_idle", ok, 1);
      chk("rr_grant", bus.grant, 1);
      chk("rr_missing_pulse", sb.size(), 0);
      sb.delete();

      // Slew held by adj_active
      @(posedge clk); #1;
      drive_req(0, 2'd1, offd(-300), 1'b1);
      handshake(0, xc, ok);
      chk("slew_handshake", ok, 1);
      sb.push_back(exp_t'{K_ADJ, xc + 2, adjp(4'hF, 16'd0, 300)});
      @(posedge clk); #1;
      drive_req(0, 2'd1, offd(-300), 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.adj_active = 1'b1;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         chk("slew_busy_hold", bus.busy, 1);
      end
      @(posedge clk); #1;
      bus.adj_active = 1'b0;
      @(negedge clk);
      chk("slew_busy_last", bus.busy, 1);
      @(negedge clk);
      chk("slew_busy_drop", bus.busy, 0);
      chk("slew_missing_pulse", sb.size(), 0);
      sb.delete();

      // Reset just after the adj_valid cycle aborts the wait
      @(posedge clk); #1;
      drive_req(1, 2'd1, offd(200), 1'b1);
      handshake(1, xc, ok);
      chk("abort_handshake", ok, 1);
      sb.push_back(exp_t'{K_ADJ, xc + 2, adjp(4'h1, 16'd0, 200)});
      @(posedge clk); #1;
      drive_req(1, 2'd1, offd(200), 1'b0);
      bus.adj_active = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_busy", bus.busy, 0);
      chk("abort_grant", bus.grant, 1);
      chk("abort_adj_count", bus.adj_count, 0);
      chk("abort_adj_pulse_seen", sb.size(), 0);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         chk("abort_stays_idle", bus.busy, 0);
      end
      bus.adj_active = 1'b0;

      // After reset a tie goes to requester 0 again
      @(posedge clk); #1;
      drive_req(0, 2'd0, tsf(3, 4, 5), 1'b1);
      drive_req(1, 2'd0, tsf(6, 7, 8), 1'b1);
      handshake(0, xc, ok);
      chk("post_rst_tie_req0", ok, 1);
      sb.push_back(exp_t'{K_TS, xc + 2, tsf(3, 4, 5)});
      @(posedge clk); #1;
      drive_req(0, 2'd0, '0, 1'b0);
      drive_req(1, 2'd0, '0, 1'b0);
      wait_idle(ok);
      chk("post_rst_idle", ok, 1);
      chk("post_rst_grant", bus.grant, 0);
      chk("post_rst_missing_pulse", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
